display_write_sequencer: RTL and testbench

- Sits between the multicycle processor's memory-write bus (MemWrite, Adr, WriteData) and the 4-digit hex display driver.
- Captures processor stores to a display-mapped address into a small FIFO.
- Schedules the display so that each captured value is shown for a fixed dwell time, in store order, even when the processor writes faster than a human can read.
- disp_data drives the display driver's 16-bit data input.

---
 rtl/display_write_sequencer.sv | 117 +++++++++++
 tb/tb_display_write_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/display_write_sequencer.sv
// display_write_sequencer: queues processor stores to a display address and shows each value for a fixed dwell time.
// Ports: clk; reset (async, active-low); MemWrite/Adr/WriteData processor store bus;
//   hold freezes the dwell timer; disp_data/disp_valid feed the hex display driver;
//   fifo_count queued entries; overflow sticky dropped-capture flag.
// Define DISPLAY_SHOW_ADDR_EN to show each entry as an address phase then a data phase (adds disp_is_addr).
module display_write_sequencer #(
  parameter int          DEPTH        = 4,
  parameter int          DWELL_CYCLES = 50000000,
  parameter logic [31:0] ADDR_MATCH   = 32'h00000064,
  parameter logic [31:0] ADDR_MASK    = 32'hFFFFFFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              Adr,
  input  logic [31:0]              WriteData,
  input  logic                     hold,
  output logic [15:0]              disp_data,
  output logic                     disp_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef DISPLAY_SHOW_ADDR_EN
  ,
  output logic                     disp_is_addr
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
`ifdef DISPLAY_SHOW_ADDR_EN
  localparam int EW = 32;
`else
  localparam int EW = 16;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, DWELL} state_t;
  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] entry, head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          q, q_d, push, pop, full, accept;
  logic          unused;
  assign unused = ^WriteData[31:16];
  assign q      = MemWrite && ((Adr & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK));
  assign push   = q && !q_d;
  assign full   = fifo_count == (AW+1)'(DEPTH);
  assign accept = push && (!full || pop);
  assign head   = mem[rptr];
`ifdef DISPLAY_SHOW_ADDR_EN
  logic          second;
  logic [15:0]   data_buf;
  assign entry = {Adr[15:0], WriteData[15:0]};
  assign pop   = state == LOAD && !second;
`else
  assign entry = WriteData[15:0];
  assign pop   = state == LOAD;
`endif
  always_ff @(posedge clk)
    if (accept) mem[wptr] <= entry;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      q_d        <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      q_d        <= q;
      wptr       <= accept ? wptr + AW'(1) : wptr;
      rptr       <= pop ? rptr + AW'(1) : rptr;
      fifo_count <= fifo_count + (AW+1)'(accept) - (AW+1)'(pop);
      overflow   <= overflow || (push && full && !pop);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
`ifdef DISPLAY_SHOW_ADDR_EN
      disp_is_addr <= 1'b0;
      second       <= 1'b0;
      data_buf     <= '0;
`endif
    end else
      case (state)
        IDLE: state <= fifo_count != '0 ? LOAD : IDLE;
        LOAD: begin
`ifdef DISPLAY_SHOW_ADDR_EN
          disp_data    <= second ? data_buf : head[31:16];
          disp_is_addr <= !second;
          data_buf     <= head[15:0];
          second       <= 1'b0;
`else
          disp_data    <= head;
`endif
          cnt        <= DWELL_LAST;
          disp_valid <= 1'b1;
          state      <= DWELL;
        end
        DWELL:
          if (!hold) begin
            if (cnt != '0) cnt <= cnt - CW'(1);
            else begin
              disp_valid <= 1'b0;
`ifdef DISPLAY_SHOW_ADDR_EN
              disp_is_addr <= 1'b0;
              second       <= disp_is_addr;
              state        <= (disp_is_addr || fifo_count != '0) ? LOAD : IDLE;
`else
              state        <= fifo_count != '0 ? LOAD : IDLE;
`endif
            end
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_display_write_sequencer.sv
// tb_display_write_sequencer: directed scoreboard bench for display_write_sequencer (DWELL_CYCLES=4, DEPTH=4).
module tb_display_write_sequencer;
  logic        clk, reset, MemWrite, hold;
  logic [31:0] Adr, WriteData;
  logic [15:0] disp_data;
  logic        disp_valid, overflow;
  logic [2:0]  fifo_count;
  int          vectors = 0;
  int          errs = 0;
  logic [15:0] sb [$];
  bit          prev_v = 0;
  bit          held = 0;
  int          run = 0;
  display_write_sequencer #(.DEPTH(4), .DWELL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .hold(hold), .disp_data(disp_data), .disp_valid(disp_valid),
    .fifo_count(fifo_count), .overflow(overflow)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1; Adr = a; WriteData = d;
    step();
    MemWrite = 0;
    step();
  endtask
  task automatic wait_valid(input logic v, input string tag);
    int n = 0;
    while (disp_valid !== v && n < 40) begin step(); n++; end
    chk(tag, disp_valid, v);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(disp_valid === 1'b0 && fifo_count === 3'd0) && n < 80) begin step(); n++; end
    chk(tag, {disp_valid, fifo_count}, 4'd0);
  endtask
  // Scoreboard monitor: each new dwell must show the oldest expected value and last 4 cycles unless held.
  always @(negedge clk) begin
    if (!reset) begin
      prev_v = 0; run = 0; held = 0;
    end else begin
      if (disp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          vectors++; errs++;
          $error("FAIL unexpected_show: observed %0h expected nothing queued", disp_data);
        end else chk("show_order", disp_data, sb.pop_front());
        run = 0; held = 0;
      end
      if (disp_valid) begin run++; if (hold) held = 1; end
      if (!disp_valid && prev_v && !held) chk("dwell_len", run, 4);
      prev_v = disp_valid;
    end
  end
  initial begin
    reset = 1; MemWrite = 0; hold = 0; Adr = 0; WriteData = 0;
    #2 reset = 0;
    #1;
    chk("rst_data", disp_data, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    step(); step();
    reset = 1;
    step();
    sb.push_back(16'hABCD);
    MemWrite = 1; Adr = 32'h64; WriteData = 32'h1234ABCD;
    step();
    chk("cap_count", fifo_count, 1);
    chk("cap_valid0", disp_valid, 0);
    MemWrite = 0;
    step();
    chk("load_valid0", disp_valid, 0);
    step();
    chk("show_valid", disp_valid, 1);
    chk("show_data", disp_data, 16'hABCD);
    chk("show_count0", fifo_count, 0);
    repeat (3) step();
    chk("dwell_last", disp_valid, 1);
    step();
    chk("idle_valid", disp_valid, 0);
    chk("idle_data", disp_data, 16'hABCD);
    MemWrite = 1; Adr = 32'h60; WriteData = 32'h0000BEEF;
    step();
    MemWrite = 0;
    chk("filt_addr_count", fifo_count, 0);
    step(); step();
    chk("filt_addr_valid", disp_valid, 0);
    sb.push_back(16'h5555);
    MemWrite = 1; Adr = 32'h64; WriteData = 32'h00005555;
    step();
    chk("held_strobe_c1", fifo_count, 1);
    step();
    chk("held_strobe_c2", fifo_count, 1);
    step();
    chk("held_strobe_c3", fifo_count, 0);
    MemWrite = 0;
    wait_idle("held_strobe_idle");
    sb.push_back(16'h00AA);
    store(32'h64, 32'h00AA);
    wait_valid(1, "ovf_first_show");
    hold = 1;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back(16'(i));
      store(32'h64, 32'(i));
    end
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_hold_data", disp_data, 16'h00AA);
    hold = 0;
    wait_idle("ovf_drain");
    chk("ovf_sticky", overflow, 1);
    reset = 0;
    step();
    reset = 1;
    step();
    chk("ovf_cleared", overflow, 0);
    sb.push_back(16'h00BB);
    store(32'h64, 32'h00BB);
    wait_valid(1, "sim_first_show");
    hold = 1;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(16'h0B00 + 16'(i));
      store(32'h64, 32'h0B00 + i);
    end
    chk("sim_full", fifo_count, 4);
    hold = 0;
    wait_valid(0, "sim_reach_load");
    chk("sim_load_data", disp_data, 16'h00BB);
    sb.push_back(16'h0B05);
    MemWrite = 1; Adr = 32'h64; WriteData = 32'h0B05;
    step();
    MemWrite = 0;
    chk("sim_count", fifo_count, 4);
    chk("sim_ovf", overflow, 0);
    chk("sim_show", disp_data, 16'h0B01);
    wait_idle("sim_drain");
    chk("sim_ovf_end", overflow, 0);
    sb.push_back(16'h0C01);
    store(32'h64, 32'h0C01);
    wait_valid(1, "mid_first_show");
    hold = 1;
    store(32'h64, 32'h0C02);
    store(32'h64, 32'h0C03);
    chk("mid_count", fifo_count, 2);
    reset = 0;
    #1;
    chk("mid_rst_data", disp_data, 0);
    chk("mid_rst_valid", disp_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    sb.delete();
    hold = 0;
    step(); step();
    reset = 1;
    repeat (10) step();
    chk("post_rst_data", disp_data, 0);
    chk("post_rst_valid", disp_valid, 0);
    chk("post_rst_count", fifo_count, 0);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
